// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the LU control-word sequencer: state codes and
// default control-word layout constants.
package ctrl_seq_pkg;

    localparam int unsigned     CTRL_WIDTH_DEF = 60;
    localparam logic [59:0]     NOP_WORD_DEF   = '0;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_HANDOFF = 3'd1;
    localparam state_t ST_RUN     = 3'd2;
    localparam state_t ST_DRAIN   = 3'd3;
    localparam state_t ST_FINISH  = 3'd4;

endpackage

// File: rtl/ctrl_word_fifo.sv
// Synchronous FIFO for control words; extra pointer MSB distinguishes full
// from empty. Read data is the head entry, valid whenever empty is low.
module ctrl_word_fifo #(
    parameter int unsigned WIDTH = 60,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        empty   = (wr_ptr == rd_ptr);
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        dout    = mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ctrl_word_sequencer.sv
// Transmit end of the LU control interface: buffers host control words and
// issues them one per cycle during a commanded run, with NOP fill and drain.
module ctrl_word_sequencer
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned           CTRL_WIDTH   = CTRL_WIDTH_DEF,
    parameter int unsigned           FIFO_DEPTH   = 16,
    parameter int unsigned           CNT_WIDTH    = 16,
    parameter int unsigned           DRAIN_CYCLES = 8,
    parameter logic [CTRL_WIDTH-1:0] NOP_WORD     = CTRL_WIDTH'(NOP_WORD_DEF)
) (
    input  logic                  CLK_100,
    input  logic                  locked,
    input  logic [CTRL_WIDTH-1:0] ctrl_in_data,
    input  logic                  ctrl_in_valid,
    output logic                  ctrl_in_ready,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  word_count,
    input  logic                  flush,
    output logic [CTRL_WIDTH-1:0] CTRL_Signal,
    output logic                  bram_ZYNQ_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  underrun,
    output logic [CNT_WIDTH-1:0]  issued_count
);

    localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

    state_t                state;
    state_t                state_nxt;
    logic [CNT_WIDTH-1:0]  run_len;
    logic [DW-1:0]         drain_cnt;
    logic [CTRL_WIDTH-1:0] fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  fifo_flush;
    logic                  last_pop;
    logic                  start_ok;

    ctrl_word_fifo #(
        .WIDTH (CTRL_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK_100),
        .rst_n (locked),
        .flush (fifo_flush),
        .push  (ctrl_in_valid),
        .pop   (fifo_pop),
        .din   (ctrl_in_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        ctrl_in_ready = !fifo_full;
        start_ok      = (state == ST_IDLE) && start;
        fifo_flush    = (state == ST_IDLE) && flush;
        fifo_pop      = (state == ST_RUN) && !fifo_empty;
        last_pop      = fifo_pop && (issued_count == run_len - CNT_WIDTH'(1));
        busy          = (state == ST_HANDOFF) || (state == ST_RUN) || (state == ST_DRAIN);
        bram_ZYNQ_sel = !busy;
        done          = (state == ST_FINISH);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start_ok) state_nxt = (word_count == '0) ? ST_FINISH : ST_HANDOFF;
            ST_HANDOFF: state_nxt = ST_RUN;
            ST_RUN:     if (last_pop) state_nxt = ST_DRAIN;
            ST_DRAIN:   if (drain_cnt == DW'(DRAIN_CYCLES)) state_nxt = ST_FINISH;
            ST_FINISH:  state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Drain count starts at 0 on the cycle the last real word is on the bus,
    // so DRAIN_CYCLES full NOP cycles follow it before FINISH.
    always_ff @(posedge CLK_100 or negedge locked) begin
        if (!locked) begin
            state        <= ST_IDLE;
            CTRL_Signal  <= NOP_WORD;
            run_len      <= '0;
            drain_cnt    <= '0;
            underrun     <= 1'b0;
            issued_count <= '0;
        end else begin
            state       <= state_nxt;
            CTRL_Signal <= fifo_pop ? fifo_dout : NOP_WORD;
            drain_cnt   <= (state == ST_DRAIN) ? drain_cnt + DW'(1) : '0;
            if (start_ok && (word_count != '0)) begin
                run_len      <= word_count;
                issued_count <= '0;
                underrun     <= 1'b0;
            end else if (state == ST_RUN) begin
                if (fifo_pop) begin
                    if (issued_count != '1) issued_count <= issued_count + CNT_WIDTH'(1);
                end else begin
                    underrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/ctrl_word_sequencer.md
Name: ctrl_word_sequencer

Overview:
- Transmit end of the LU datapath control interface.
- Buffers control words pushed by the ZYNQ-side host and issues exactly one registered word per cycle on CTRL_Signal for a commanded run.
- Inserts NOP words on underrun, then issues NOPs for a fixed drain period after the last real word.
- Hands BRAM ownership between host and datapath through bram_ZYNQ_sel.

Parameters:
- CTRL_WIDTH, 60, width of one control word.
- FIFO_DEPTH, 16, control-word buffer depth; power of two.
- CNT_WIDTH, 16, width of the run word counter.
- DRAIN_CYCLES, 8, NOP cycles issued after the last word; covers MAC/DIV latency.
- NOP_WORD, 0, control word driven whenever no real word is issued; all write enables inactive.

Ports:
- CLK_100  in  1  single clock.
- locked  in  1  asynchronous active-low reset.
- ctrl_in_data  in  CTRL_WIDTH  host control word.
- ctrl_in_valid  in  1  host word valid.
- ctrl_in_ready  out  1  buffer can accept.
- start  in  1  one-cycle run request.
- word_count  in  CNT_WIDTH  number of real words in the run; sampled on start.
- flush  in  1  clears buffer; honoured in IDLE only.
- CTRL_Signal  out  CTRL_WIDTH  registered control word to the datapath.
- bram_ZYNQ_sel  out  1  1 = host owns BRAM port A, 0 = datapath owns it.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run end.
- underrun  out  1  sticky; set if a NOP was inserted for an empty buffer during RUN; cleared on accepted start.
- issued_count  out  CNT_WIDTH  real words issued in the current/last run.

Behaviour:
- Reset (locked=0, async) values:
  - CTRL_Signal = NOP_WORD, bram_ZYNQ_sel = 1, busy/done/underrun = 0, issued_count = 0.
  - Buffer empty, state IDLE.
- Buffer:
  - Push when ctrl_in_valid && ctrl_in_ready.
  - ctrl_in_ready = !full; no push-through when full even if a pop occurs that cycle.
  - A word pushed in cycle t is poppable in cycle t+1.
  - Pushes are accepted in every state, so the host may prefill in IDLE.
- States: IDLE, HANDOFF, RUN, DRAIN, FINISH.
- IDLE:
  - sel = 1, CTRL = NOP.
  - flush empties the buffer in the next cycle; flush outside IDLE is ignored.
  - start with word_count = 0 -> FINISH directly; sel stays 1.
  - start with word_count > 0 -> latch count, clear underrun and issued_count, go to HANDOFF.
- HANDOFF (1 cycle): sel = 0, busy = 1, CTRL = NOP.
- RUN:
  - Each cycle, if the buffer is non-empty: pop; the popped word appears on CTRL_Signal the next cycle; issued_count++.
  - If the buffer is empty: CTRL = NOP next cycle, underrun set.
  - When issued_count reaches the latched count (on the cycle of the last pop) -> DRAIN.
- DRAIN:
  - Exactly DRAIN_CYCLES cycles of CTRL = NOP, counted from the cycle after the last real word appears.
  - Then -> FINISH.
- FINISH (1 cycle): done = 1, sel = 1, busy = 0, then IDLE.
- start outside IDLE is ignored; word_count is not re-sampled.
- Surplus buffered words beyond word_count remain for the next run.
- Counter: issued_count saturates at its maximum; the latched count is at most 2^CNT_WIDTH-1.
- Reset mid-run: outputs return to reset values immediately (async); buffer contents are lost.
- Pop and push in the same cycle on a non-full buffer: both occur; occupancy is unchanged.

Decomposition:
- Shared package ctrl_seq_pkg: state enumeration; NOP_WORD default; CTRL_WIDTH default consistent with the datapath field layout.
- Sub-module ctrl_word_fifo: synchronous FIFO, parameterised width and depth.
  - Ports: push, pop, data in/out, full, empty, flush.
  - Pointer wrap uses an extra MSB for full/empty.

Test Plan:
- Prefill 3 words A, B, C, then start with word_count=3:
  - Required: sel falls 1 cycle after start.
  - CTRL = A, B, C on 3 consecutive cycles starting 3 cycles after start.
  - 8 NOPs follow, then a done pulse with sel=1; issued_count=3, underrun=0.
- Start with word_count=2 and an empty buffer; push W0 at +4 and W1 at +7:
  - Required: NOPs before each word, W0 and W1 each issued once.
  - underrun=1, done after 8 NOP drain cycles.
- start with word_count=0 -> done pulses the next cycle; sel never leaves 1; busy stays 0.
- Push 17 words with valid held high, no run active:
  - Required: ctrl_in_ready drops after 16 accepted; the 17th is held until a pop frees space.
  - A subsequent run of 16 issues them in order.
- Assert locked=0 during RUN after 2 of 5 words:
  - Required: CTRL = NOP, sel=1, busy=0 asynchronously.
  - After release the buffer is empty and the FSM is in IDLE.
- Start pulses during RUN and DRAIN, plus flush during RUN:
  - Required: all ignored; exactly one done pulse.
  - Surplus words are still present afterwards.
